// File: rtl/key_event_scheduler.sv
// Pushbutton front end: sync + debounce per key, press/release detection, pending-event queue, round-robin valid/ready event channel.
// Define KEY_SCHED_DEBOUNCE_EN to build the debounce counters; otherwise the synchronizer output is taken as the accepted level.
module key_event_scheduler #(
  parameter int NUM_KEYS        = 4,
  parameter int ID_WIDTH        = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_n,
  input  logic                event_ready,
  output logic                event_valid,
  output logic [ID_WIDTH-1:0] event_id,
  output logic [NUM_KEYS-1:0] pending,
  output logic                overrun
);

  if (DEBOUNCE_CYCLES < 1 || CNT_WIDTH < 1 || (1 << ID_WIDTH) < NUM_KEYS) begin : g_bad_cfg
    $error("key_event_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {KEY_FREE, KEY_PRESSED, KEY_RELEASED} key_state_t;
  typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_t;

  logic [NUM_KEYS-1:0] sync_p0, sync_p1, level_p2;
  key_state_t          key_state [NUM_KEYS];
  logic [NUM_KEYS-1:0] rel, clr;
  logic                take;
  arb_state_t          arb_state;
  logic [ID_WIDTH-1:0] rr_ptr;

  // First set request bit at or after ptr, wrapping at NUM_KEYS.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_KEYS-1:0] req,
                                                  input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH-1:0] pick;
    logic                found;
    int                  idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      idx = (int'(ptr) + k) % NUM_KEYS;
      if (!found && req[idx]) begin
        pick  = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Stage p0/p1: two-flop synchronizer, released level on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= keys_n;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: accepted (debounced) level.
`ifdef KEY_SCHED_DEBOUNCE_EN
  logic [CNT_WIDTH-1:0] cnt [NUM_KEYS];

  always_ff @(posedge clock) begin
    if (reset) begin
      level_p2 <= '1;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync_p1[i] == level_p2[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
          level_p2[i] <= sync_p1[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign level_p2 = sync_p1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) key_state[i] <= KEY_FREE;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        case (key_state[i])
          KEY_FREE:     if (!level_p2[i]) key_state[i] <= KEY_PRESSED;
          KEY_PRESSED:  if (level_p2[i])  key_state[i] <= KEY_RELEASED;
          default:      key_state[i] <= KEY_FREE;
        endcase
      end
    end
  end

  always_comb begin
    rel = '0;
    for (int i = 0; i < NUM_KEYS; i++) rel[i] = (key_state[i] == KEY_RELEASED);
  end

  assign take = event_valid & event_ready;
  assign clr  = take ? (NUM_KEYS'(1) << event_id) : '0;

  // A new release beats a same-cycle handshake clear of the same key.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | rel;
      if (|(rel & pending & ~clr)) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      arb_state   <= ARB_IDLE;
      event_valid <= 1'b0;
      event_id    <= '0;
      rr_ptr      <= '0;
    end else begin
      case (arb_state)
        ARB_IDLE: if (|pending) begin
          event_id    <= rr_pick(pending, rr_ptr);
          event_valid <= 1'b1;
          arb_state   <= ARB_OFFER;
        end
        ARB_OFFER: if (event_ready) begin
          event_valid <= 1'b0;
          rr_ptr      <= ID_WIDTH'((int'(event_id) + 1) % NUM_KEYS);
          arb_state   <= ARB_IDLE;
        end
        default: arb_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
